// File: rtl/rvc_instr_aligner.sv
// RV32 fetch-to-instruction aligner. With FROST_RVC_ALIGN_EN defined, a 3-halfword parcel
// buffer splits/joins RVC and 32-bit instructions; otherwise each fetch word passes through one register.
module rvc_instr_aligner (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_valid,
    input  logic [31:0] i_fetch_data,
    input  logic [31:0] i_fetch_pc,
    output logic        o_fetch_ready,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_is_compressed,
    input  logic        i_instr_ready,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc
);

`ifdef FROST_RVC_ALIGN_EN
    logic [2:0][15:0] parcel_q, parcel_d, shifted;
    logic [1:0][15:0] new_hw;
    logic [1:0]       count_q, count_d, pop_n, rem, n_new;
    logic [31:0]      buf_pc_q, buf_pc_d;
    logic             skip_q, skip_d;
    logic             oldest_c, instr_vld, accept, pop;
    logic             unused_bits;

    assign unused_bits = ^{i_fetch_pc[1:0], i_flush_pc[31:2], i_flush_pc[0]};

    assign oldest_c  = parcel_q[0][1:0] != 2'b11;
    assign instr_vld = (count_q >= 2'd2) || (count_q == 2'd1 && oldest_c);

    assign o_fetch_ready         = count_q <= 2'd1;
    assign o_instr_valid         = instr_vld;
    assign o_instr_is_compressed = instr_vld && oldest_c;
    assign o_instr               = !instr_vld ? 32'h0 :
                                   oldest_c   ? {16'h0, parcel_q[0]} : {parcel_q[1], parcel_q[0]};
    assign o_instr_pc            = buf_pc_q;

    assign accept = i_fetch_valid && o_fetch_ready;
    assign pop    = instr_vld && i_instr_ready;
    assign pop_n  = !pop ? 2'd0 : (oldest_c ? 2'd1 : 2'd2);
    assign rem    = count_q - pop_n;
    assign n_new  = skip_q ? 2'd1 : 2'd2;
    // After a redirect to an odd halfword only the upper half of the first word is kept.
    assign new_hw = skip_q ? {16'h0, i_fetch_data[31:16]} : i_fetch_data;

    always_comb begin
        case (pop_n)
            2'd1:    shifted = {16'h0, parcel_q[2], parcel_q[1]};
            2'd2:    shifted = {32'h0, parcel_q[2]};
            default: shifted = parcel_q;
        endcase
        parcel_d = shifted;
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                if (2'(i) == rem)
                    parcel_d[i] = new_hw[0];
                else if (2'(i) == rem + 2'd1 && n_new == 2'd2)
                    parcel_d[i] = new_hw[1];
            end
        end
        count_d  = rem + (accept ? n_new : 2'd0);
        skip_d   = accept ? 1'b0 : skip_q;
        buf_pc_d = buf_pc_q;
        if (accept && count_q == 2'd0)
            buf_pc_d = {i_fetch_pc[31:2], skip_q, 1'b0};
        else if (pop)
            buf_pc_d = buf_pc_q + {29'h0, pop_n, 1'b0};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            parcel_q <= '0;
            count_q  <= 2'd0;
            buf_pc_q <= 32'h0;
            skip_q   <= 1'b0;
        end else if (i_flush) begin
            count_q <= 2'd0;
            skip_q  <= i_flush_pc[1];
        end else begin
            parcel_q <= parcel_d;
            count_q  <= count_d;
            buf_pc_q <= buf_pc_d;
            skip_q   <= skip_d;
        end
    end

`else
    logic        vld_q;
    logic [31:0] instr_q, pc_q;
    logic        unused_bits;

    assign unused_bits = ^{i_fetch_pc[1:0], i_flush_pc};

    assign o_fetch_ready         = !vld_q || i_instr_ready;
    assign o_instr_valid         = vld_q;
    assign o_instr               = instr_q;
    assign o_instr_pc            = pc_q;
    assign o_instr_is_compressed = 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q   <= 1'b0;
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
        end else if (i_flush) begin
            vld_q <= 1'b0;
        end else if (i_fetch_valid && o_fetch_ready) begin
            vld_q   <= 1'b1;
            instr_q <= i_fetch_data;
            pc_q    <= {i_fetch_pc[31:2], 2'b00};
        end else if (i_instr_ready) begin
            vld_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_rvc_instr_aligner.sv
// Self-checking bench for rvc_instr_aligner: directed cases plus a randomized run against a
// halfword-stream reference model. Covers both FROST_RVC_ALIGN_EN builds.
module tb_rvc_instr_aligner;
    logic        clk = 1'b0;
    logic        rst, fv, rdy, fl;
    logic [31:0] fd, fpc, flpc;
    logic        f_rdy, i_vld, i_c;
    logic [31:0] instr, ipc;
    int          tests = 0;
    int          fails = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] words[64];

    always #5 clk = ~clk;

    rvc_instr_aligner dut (
        .i_clk(clk), .i_rst(rst),
        .i_fetch_valid(fv), .i_fetch_data(fd), .i_fetch_pc(fpc), .o_fetch_ready(f_rdy),
        .o_instr_valid(i_vld), .o_instr(instr), .o_instr_pc(ipc), .o_instr_is_compressed(i_c),
        .i_instr_ready(rdy), .i_flush(fl), .i_flush_pc(flpc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] pc, input logic c);
        chk({tag, "_valid"}, {31'h0, i_vld}, {31'h0, v});
        if (v) begin
            chk({tag, "_instr"}, instr, ins);
            chk({tag, "_pc"}, ipc, pc);
            chk({tag, "_c"}, {31'h0, i_c}, {31'h0, c});
        end
    endtask

    task automatic do_flush(input logic [31:0] pc);
        fv = 1'b0; fl = 1'b1; flpc = pc;
        step();
        fl = 1'b0;
    endtask

    // Reference: expected instruction stream derived from the sequential halfword stream.
    task automatic build_expect(input int n, input logic [31:0] base, input logic sk);
        exp_t        e;
        logic [15:0] hs[$];
        logic [15:0] h0, h1;
        int          k;
        expq = {};
`ifdef FROST_RVC_ALIGN_EN
        for (int i = 0; i < n; i++) begin
            hs.push_back(words[i][15:0]);
            hs.push_back(words[i][31:16]);
        end
        k = sk ? 1 : 0;
        while (k < hs.size()) begin
            h0 = hs[k];
            e.pc = base + 32'(2 * k);
            if (h0[1:0] != 2'b11) begin
                e.instr = {16'h0, h0}; e.c = 1'b1; expq.push_back(e); k += 1;
            end else if (k + 1 < hs.size()) begin
                h1 = hs[k+1];
                e.instr = {h1, h0}; e.c = 1'b0; expq.push_back(e); k += 2;
            end else begin
                break;
            end
        end
`else
        k = sk ? 1 : 0;
        for (int i = 0; i < n; i++) begin
            e.instr = words[i]; e.pc = base + 32'(4 * i); e.c = 1'b0; expq.push_back(e);
        end
`endif
    endtask

    task automatic random_run(input int n);
        logic [31:0] base, pi, ppc, w;
        logic        sk, pv;
        int          widx, guard;
        exp_t        e;
        base = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
        sk   = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
            words[i] = w;
        end
        build_expect(n, base, sk);
        do_flush(base | {30'h0, sk, 1'b0});
        widx = 0; pv = 1'b0; guard = 0; pi = '0; ppc = '0;
        while ((widx < n || expq.size() != 0) && guard < 3000) begin
            fv  = (widx < n) && ($urandom_range(0, 3) != 0);
            fd  = (widx < n) ? words[widx] : 32'h0;
            fpc = base + 32'(4 * widx) + 32'($urandom_range(0, 3));
            rdy = $urandom_range(0, 2) != 0;
            #1;
            if (pv) begin
                chk("hold_valid", {31'h0, i_vld}, 32'h1);
                chk("hold_instr", instr, pi);
                chk("hold_pc", ipc, ppc);
            end
            if (i_vld && rdy) begin
                if (expq.size() == 0) begin
                    chk("extra_valid", {31'h0, i_vld}, 32'h0);
                end else begin
                    e = expq.pop_front();
                    chk("rnd_instr", instr, e.instr);
                    chk("rnd_pc", ipc, e.pc);
                    chk("rnd_c", {31'h0, i_c}, {31'h0, e.c});
                end
            end
            pv = i_vld && !rdy; pi = instr; ppc = ipc;
            if (fv && f_rdy) widx++;
            step();
            guard++;
        end
        chk("rnd_left", 32'(expq.size()), 32'h0);
        fv = 1'b0; rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fv = 1'b0; rdy = 1'b0; fl = 1'b0; fd = '0; fpc = '0; flpc = '0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_valid", {31'h0, i_vld}, 32'h0);
        chk("rst_fready", {31'h0, f_rdy}, 32'h1);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", ipc, 32'h0);
        chk("rst_c", {31'h0, i_c}, 32'h0);
`ifdef FROST_RVC_ALIGN_EN
        // Two RVC parcels in one word.
        fv = 1'b1; fd = 32'h4505_0505; fpc = 32'h100; rdy = 1'b1;
        step(); fv = 1'b0; #1;
        chk_out("r19a", 1'b1, 32'h0000_0505, 32'h100, 1'b1);
        step();
        chk_out("r19b", 1'b1, 32'h0000_4505, 32'h102, 1'b1);
        step();
        chk_out("r19c", 1'b0, 32'h0, 32'h0, 1'b0);

        // 32-bit instruction straddling two fetch words.
        fv = 1'b1; fd = 32'h0093_0001; fpc = 32'h200;
        step(); fd = 32'h1234_0010; fpc = 32'h204; #1;
        chk_out("r20a", 1'b1, 32'h0000_0001, 32'h200, 1'b1);
        chk("r20a_fready", {31'h0, f_rdy}, 32'h0);
        step();
        chk_out("r20_held", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("r20_fready", {31'h0, f_rdy}, 32'h1);
        step(); fv = 1'b0; #1;
        chk_out("r20b", 1'b1, 32'h0010_0093, 32'h202, 1'b0);
        step();
        chk_out("r20c", 1'b1, 32'h0000_1234, 32'h206, 1'b1);
        step();
        chk_out("r20d", 1'b0, 32'h0, 32'h0, 1'b0);

        // Redirect to the odd halfword of a word.
        do_flush(32'h302); #1;
        chk_out("r21_flush", 1'b0, 32'h0, 32'h0, 1'b0);
        fv = 1'b1; fd = 32'h0505_FFFF; fpc = 32'h300;
        step(); fv = 1'b0; #1;
        chk_out("r21a", 1'b1, 32'h0000_0505, 32'h302, 1'b1);
        step();
        chk_out("r21b", 1'b0, 32'h0, 32'h0, 1'b0);

        // Back-pressure: buffer fills to three parcels and holds.
        do_flush(32'h502);
        rdy = 1'b0; fv = 1'b1; fd = 32'h1101_2201; fpc = 32'h500;
        step(); fd = 32'h3301_4401; fpc = 32'h504;
        step(); fd = 32'h5501_6601; fpc = 32'h508;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("r22_fready", {31'h0, f_rdy}, 32'h0);
            chk_out("r22_hold", 1'b1, 32'h0000_1101, 32'h502, 1'b1);
            step();
        end
        fv = 1'b0; rdy = 1'b1; #1;
        chk_out("r22a", 1'b1, 32'h0000_1101, 32'h502, 1'b1);
        step();
        chk_out("r22b", 1'b1, 32'h0000_4401, 32'h504, 1'b1);
        step();
        chk_out("r22c", 1'b1, 32'h0000_3301, 32'h506, 1'b1);
        step();
        chk_out("r22d", 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset with a full buffer.
        do_flush(32'h602);
        rdy = 1'b0; fv = 1'b1; fd = 32'h1101_2201; fpc = 32'h600;
        step(); fd = 32'h3301_4401; fpc = 32'h604;
        step(); fv = 1'b0; #1;
        chk("r23_full", {31'h0, f_rdy}, 32'h0);
        rst = 1'b1;
        step(); rst = 1'b0; #1;
        chk_out("r23_rst", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("r23_fready", {31'h0, f_rdy}, 32'h1);
        chk("r23_instr", instr, 32'h0);
        fv = 1'b1; fd = 32'h7777_0009; fpc = 32'h0; rdy = 1'b1;
        step(); fv = 1'b0; #1;
        chk_out("r23a", 1'b1, 32'h0000_0009, 32'h0, 1'b1);
        step();
`else
        // Pass-through: whole word, one-cycle latency.
        fv = 1'b1; fd = 32'h00A0_0093; fpc = 32'h400; rdy = 1'b1;
        step(); fv = 1'b0; #1;
        chk_out("r24", 1'b1, 32'h00A0_0093, 32'h400, 1'b0);
        rdy = 1'b0; #1;
        chk("bp_fready", {31'h0, f_rdy}, 32'h0);
        fv = 1'b1; fd = 32'h1111_1113; fpc = 32'h407;
        step();
        chk_out("bp_hold", 1'b1, 32'h00A0_0093, 32'h400, 1'b0);
        rdy = 1'b1; #1;
        chk("bp_fready2", {31'h0, f_rdy}, 32'h1);
        step(); fv = 1'b0; #1;
        chk_out("bp_next", 1'b1, 32'h1111_1113, 32'h404, 1'b0);
        step();
        chk_out("drain", 1'b0, 32'h0, 32'h0, 1'b0);
        fv = 1'b1; fd = 32'hDEAD_BEEF; fpc = 32'h800; fl = 1'b1; flpc = 32'h800;
        step(); fv = 1'b0; fl = 1'b0; #1;
        chk_out("flush_drop", 1'b0, 32'h0, 32'h0, 1'b0);
`endif
        random_run(48);
        random_run(32);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
